// File: rtl/rx_cpl_host_mem_pkg.sv
// Shared constants for the CplD receive path: TRN header field positions,
// the CplD fmt/type code, one-hot state encodings and a header-1 decoder.
package rx_cpl_host_mem_pkg;

    localparam int NUMB_TAGS = 16;
    localparam int TAG_W     = $clog2(NUMB_TAGS);
    localparam int SLOT_QW_W = 6;
    localparam int BUF_AW    = TAG_W + SLOT_QW_W;

    localparam logic [6:0] CPLD_FMT_TYPE = 7'b10_01010;
    localparam logic [7:0] REM_UPPER_DW  = 8'h0F;

    localparam int FMT_TYPE_LSB = 56;
    localparam int LEN_LSB      = 32;
    localparam int STATUS_LSB   = 13;
    localparam int BCNT_LSB     = 0;
    localparam int TAG_LSB      = 40;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'b0001,
        ST_HDR2    = 4'b0010,
        ST_PAYLOAD = 4'b0100,
        ST_DROP    = 4'b1000
    } rx_state_e;

    typedef struct packed {
        logic [6:0]  fmt_type;
        logic [9:0]  length;
        logic [2:0]  status;
        logic [11:0] byte_count;
    } hdr1_t;

    function automatic hdr1_t get_hdr1(input logic [63:0] rd);
        hdr1_t h;
        h.fmt_type   = rd[FMT_TYPE_LSB +: 7];
        h.length     = rd[LEN_LSB +: 10];
        h.status     = rd[STATUS_LSB +: 3];
        h.byte_count = rd[BCNT_LSB +: 12];
        return h;
    endfunction

    // Only successful CplDs with an even, nonzero DW count map onto whole qwords.
    function automatic logic hdr1_ok(input hdr1_t h);
        return (h.fmt_type == CPLD_FMT_TYPE) && (h.status == 3'b000) &&
               (h.length[0] == 1'b0) && (h.length != 10'd0);
    endfunction

endpackage

// File: rtl/rx_cpl_host_mem_if.sv
// TRN RX bus between the PCIe core (master) and the completion receiver (slave).
interface rx_cpl_host_mem_if;
    logic [63:0] trn_rd;
    logic [7:0]  trn_rrem_n;
    logic        trn_rsof_n;
    logic        trn_reof_n;
    logic        trn_rsrc_rdy_n;
    logic        trn_rdst_rdy_n;
    logic        trn_rerrfwd_n;

    modport master (
        output trn_rd, trn_rrem_n, trn_rsof_n, trn_reof_n, trn_rsrc_rdy_n, trn_rerrfwd_n,
        input  trn_rdst_rdy_n
    );

    modport slave (
        input  trn_rd, trn_rrem_n, trn_rsof_n, trn_reof_n, trn_rsrc_rdy_n, trn_rerrfwd_n,
        output trn_rdst_rdy_n
    );
endinterface

// File: rtl/rx_cpl_host_mem_realign.sv
// rx_cpl_realign: packs the DW-misaligned CplD payload into qwords by carrying
// the low DW of each beat over to pair with the high DW of the next one.
module rx_cpl_realign (
    input  logic        trn_clk,
    input  logic        reset_n,
    input  logic        load_hold,
    input  logic        push,
    input  logic [63:0] rd,
    output logic [63:0] wr_data,
    output logic        wr_en
);

    logic [31:0] hold;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge trn_clk or negedge reset_n) begin
        if (!reset_n) begin
            hold    <= '0;
            wr_data <= '0;
            wr_en   <= 1'b0;
        end else begin
            wr_en <= push;
            if (push)
                wr_data <= {hold, rd[63:32]};
            if (load_hold || push)
                hold <= rd[31:0];
        end
    end

endmodule

// File: rtl/rx_cpl_host_mem.sv
// Receives host-memory CplDs on TRN RX and writes qwords into a tag-sliced buffer.
// Define RX_CPL_ERR_CNT_EN to add a saturating cpl_err_cnt output.
module rx_cpl_host_mem
    import rx_cpl_host_mem_pkg::*;
(
    input  logic                trn_clk,
    input  logic                reset_n,
    rx_cpl_host_mem_if.slave    trn,
    output logic [BUF_AW-1:0]   wr_addr,
    output logic [63:0]         wr_data,
    output logic                wr_en,
    output logic                chunk_done,
    output logic [TAG_W-1:0]    chunk_done_tag,
    output logic                cpl_err
`ifdef RX_CPL_ERR_CNT_EN
   ,output logic [15:0]         cpl_err_cnt
`endif
);

    rx_state_e            state, state_nxt;
    hdr1_t                hdr;
    logic                 beat, sof, eof, no_fwd_err;
    logic [7:0]           tag_in;
    logic [TAG_W-1:0]     tag_q;
    logic [9:0]           len_q, dw_left;
    logic [11:0]          bc_q;
    logic [SLOT_QW_W-1:0] qw_idx;
    logic [SLOT_QW_W-1:0] offset [NUMB_TAGS];
    logic                 payload_ok, tlp_last;
    logic                 load_hdr, load_tag, push, finish, err;

    assign beat       = !trn.trn_rsrc_rdy_n && !trn.trn_rdst_rdy_n;
    assign sof        = !trn.trn_rsof_n;
    assign eof        = !trn.trn_reof_n;
    assign no_fwd_err = trn.trn_rerrfwd_n;
    assign hdr        = get_hdr1(trn.trn_rd);
    assign tag_in     = trn.trn_rd[TAG_LSB +: 8];

    // The beat holding the last odd DW must be the EOF beat with only the upper DW valid.
    assign payload_ok = no_fwd_err && (eof == (dw_left == 10'd1)) &&
                        (!eof || trn.trn_rrem_n == REM_UPPER_DW);
    assign tlp_last   = ({len_q, 2'b00} == bc_q);

    // NOTE: every output of this block gets a default first so no path infers a latch.
    always_comb begin
        state_nxt = state;
        load_hdr  = 1'b0;
        load_tag  = 1'b0;
        push      = 1'b0;
        finish    = 1'b0;
        err       = 1'b0;
        if (beat) begin
            unique case (state)
                ST_IDLE: if (sof) begin
                    load_hdr = 1'b1;
                    if (eof)                            err       = 1'b1;
                    else if (hdr1_ok(hdr) && no_fwd_err) state_nxt = ST_HDR2;
                    else                                state_nxt = ST_DROP;
                end
                ST_HDR2: begin
                    if (eof) begin
                        err       = 1'b1;
                        state_nxt = ST_IDLE;
                    end else if (tag_in[7:TAG_W] == '0 && no_fwd_err) begin
                        load_tag  = 1'b1;
                        state_nxt = ST_PAYLOAD;
                    end else begin
                        state_nxt = ST_DROP;
                    end
                end
                ST_PAYLOAD: begin
                    push = payload_ok;
                    if (eof) begin
                        finish    = payload_ok;
                        err       = !payload_ok;
                        state_nxt = ST_IDLE;
                    end else if (!payload_ok) begin
                        state_nxt = ST_DROP;
                    end
                end
                ST_DROP: if (eof) begin
                    err       = 1'b1;
                    state_nxt = ST_IDLE;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // NOTE: the per-tag offsets are flops, not RAM, and must restart at zero
    // after reset, so they sit on the async reset like any other state.
    always_ff @(posedge trn_clk or negedge reset_n) begin
        if (!reset_n) begin
            state              <= ST_IDLE;
            trn.trn_rdst_rdy_n <= 1'b1;
            len_q              <= '0;
            bc_q               <= '0;
            tag_q              <= '0;
            dw_left            <= '0;
            qw_idx             <= '0;
            wr_addr            <= '0;
            chunk_done         <= 1'b0;
            chunk_done_tag     <= '0;
            cpl_err            <= 1'b0;
            for (int i = 0; i < NUMB_TAGS; i++)
                offset[i] <= '0;
        end else begin
            state              <= state_nxt;
            trn.trn_rdst_rdy_n <= 1'b0;
            cpl_err            <= err;
            chunk_done         <= finish && tlp_last;
            if (load_hdr) begin
                len_q <= hdr.length;
                bc_q  <= hdr.byte_count;
            end
            if (load_tag) begin
                tag_q   <= tag_in[TAG_W-1:0];
                dw_left <= len_q - 10'd1;
                qw_idx  <= '0;
            end
            if (push) begin
                dw_left <= dw_left - 10'd2;
                qw_idx  <= qw_idx + 1'b1;
                wr_addr <= {tag_q, offset[tag_q] + qw_idx};
            end
            if (finish) begin
                offset[tag_q] <= tlp_last ? '0 : offset[tag_q] + len_q[SLOT_QW_W:1];
                if (tlp_last)
                    chunk_done_tag <= tag_q;
            end
        end
    end

`ifdef RX_CPL_ERR_CNT_EN
    always_ff @(posedge trn_clk or negedge reset_n) begin
        if (!reset_n)
            cpl_err_cnt <= '0;
        else if (cpl_err && cpl_err_cnt != 16'hFFFF)
            cpl_err_cnt <= cpl_err_cnt + 16'd1;
    end
`endif

    rx_cpl_realign u_realign (
        .trn_clk   (trn_clk),
        .reset_n   (reset_n),
        .load_hold (load_tag),
        .push      (push),
        .rd        (trn.trn_rd),
        .wr_data   (wr_data),
        .wr_en     (wr_en)
    );

endmodule

// File: tb/tb_rx_cpl_host_mem.sv
// Directed bench for rx_cpl_host_mem; buffer writes, chunk_done and cpl_err
// are logged on the falling edge and compared with hand-derived expectations.
module tb_rx_cpl_host_mem;
    import rx_cpl_host_mem_pkg::*;

    logic trn_clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 trn_clk = ~trn_clk;

    rx_cpl_host_mem_if trn();

    logic [BUF_AW-1:0] wr_addr;
    logic [63:0]       wr_data;
    logic              wr_en, chunk_done, cpl_err;
    logic [TAG_W-1:0]  chunk_done_tag;
`ifdef RX_CPL_ERR_CNT_EN
    logic [15:0]       cpl_err_cnt;
`endif

    rx_cpl_host_mem dut (
        .trn_clk        (trn_clk),
        .reset_n        (reset_n),
        .trn            (trn),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .wr_en          (wr_en),
        .chunk_done     (chunk_done),
        .chunk_done_tag (chunk_done_tag),
        .cpl_err        (cpl_err)
`ifdef RX_CPL_ERR_CNT_EN
       ,.cpl_err_cnt    (cpl_err_cnt)
`endif
    );

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [73:0] wq[$];
    logic [4:0]  cq[$];
    int          err_seen = 0;

    always @(negedge trn_clk) begin
        if (reset_n) begin
            if (wr_en)      wq.push_back({wr_addr, wr_data});
            if (chunk_done) cq.push_back({wr_en, chunk_done_tag});
            if (cpl_err)    err_seen++;
        end
    end

    function automatic logic [31:0] dw(input logic [7:0] t, input int i);
        return {8'hD0, t, 16'(i)};
    endfunction

    function automatic logic [63:0] hdr1(input logic [9:0] len, input logic [11:0] bc,
                                         input logic [2:0] st);
        return {1'b0, CPLD_FMT_TYPE, 14'h0, len, 16'h0100, st, 1'b0, bc};
    endfunction

    task automatic beat(input logic [63:0] d, input logic sof, input logic eof,
                        input logic [7:0] rrem, input logic poison);
        @(negedge trn_clk);
        trn.trn_rd         = d;
        trn.trn_rsof_n     = ~sof;
        trn.trn_reof_n     = ~eof;
        trn.trn_rrem_n     = rrem;
        trn.trn_rerrfwd_n  = ~poison;
        trn.trn_rsrc_rdy_n = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge trn_clk);
            trn.trn_rsrc_rdy_n = 1'b1;
            trn.trn_rsof_n     = 1'b1;
            trn.trn_reof_n     = 1'b1;
            trn.trn_rerrfwd_n  = 1'b1;
        end
    endtask

    // poison_at / eof_at select a payload beat to poison or to end early (-1 = none).
    task automatic send_cpl(input logic [7:0] t, input logic [9:0] len, input logic [11:0] bc,
                            input logic [2:0] st, input int poison_at, input int eof_at);
        int   nb;
        logic last;
        nb = int'(len) / 2;
        beat(hdr1(len, bc, st), 1'b1, 1'b0, 8'h00, 1'b0);
        beat({16'h0200, t, 8'h00, dw(t, 0)}, 1'b0, 1'b0, 8'h00, 1'b0);
        for (int k = 0; k < nb; k++) begin
            last = (k == nb - 1);
            if (k == eof_at)
                beat({dw(t, 2*k+1), dw(t, 2*k+2)}, 1'b0, 1'b1, 8'h00, 1'b0);
            else
                beat({dw(t, 2*k+1), last ? 32'h0 : dw(t, 2*k+2)}, 1'b0, last,
                     last ? 8'h0F : 8'h00, k == poison_at);
            if (k == eof_at) break;
        end
    endtask

    task automatic expect_wr(input string name, input logic [7:0] t, input int off0, input int n);
        logic [73:0] e;
        for (int i = 0; i < n; i++) begin
            if (wq.size() == 0) break;
            e = wq.pop_front();
            check($sformatf("%s_addr%0d", name, i), e[73:64],
                  {t[TAG_W-1:0], SLOT_QW_W'(off0 + i)});
            check($sformatf("%s_data%0d", name, i), e[63:0], {dw(t, 2*i), dw(t, 2*i+1)});
        end
    endtask

    task automatic expect_done(input string name, input logic [3:0] t);
        if (cq.size() > 0)
            check(name, cq.pop_front(), {1'b1, t});
    endtask

    task automatic flush();
        wq.delete();
        cq.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        trn.trn_rd = '0;  trn.trn_rrem_n = '0;  trn.trn_rsof_n = 1'b1;
        trn.trn_reof_n = 1'b1;  trn.trn_rsrc_rdy_n = 1'b1;  trn.trn_rerrfwd_n = 1'b1;

        // Reset values
        #12;
        check("rst_dst_rdy_n", trn.trn_rdst_rdy_n, 1'b1);
        check("rst_wr_en", wr_en, 1'b0);
        check("rst_chunk_done", chunk_done, 1'b0);
        check("rst_cpl_err", cpl_err, 1'b0);
        check("rst_wr_addr", wr_addr, '0);
        @(negedge trn_clk);
        reset_n = 1'b1;
        @(negedge trn_clk);
        check("rdy_after_rst", trn.trn_rdst_rdy_n, 1'b0);

        // Non-SOF beat in IDLE is ignored
        beat(64'hDEAD_BEEF_0000_0001, 1'b0, 1'b1, 8'h0F, 1'b0);
        idle(2);
        check("nosof_nwr", wq.size(), 0);
        check("nosof_err", err_seen, 0);

        // Single CplD, tag 3, length 2: write lands the cycle after the EOF beat
        send_cpl(8'd3, 10'd2, 12'd8, 3'b000, -1, -1);
        idle(1);
        check("t3_wr_en", wr_en, 1'b1);
        check("t3_wr_addr", wr_addr, 10'h0C0);
        check("t3_wr_data", wr_data, 64'hD003_0000_D003_0001);
        check("t3_chunk_done", chunk_done, 1'b1);
        check("t3_done_tag", chunk_done_tag, 4'd3);
        idle(2);
        check("t3_nwr", wq.size(), 1);
        flush();

        // Tag 5, 128 DW split over two completions
        send_cpl(8'd5, 10'd64, 12'd512, 3'b000, -1, -1);
        idle(3);
        check("t5a_nwr", wq.size(), 32);
        check("t5a_ndone", cq.size(), 0);
        expect_wr("t5a", 8'd5, 0, 32);
        send_cpl(8'd5, 10'd64, 12'd256, 3'b000, -1, -1);
        idle(3);
        check("t5b_nwr", wq.size(), 32);
        check("t5b_ndone", cq.size(), 1);
        expect_wr("t5b", 8'd5, 32, 32);
        expect_done("t5b_done", 4'd5);
        flush();

        // Unsupported-request status is dropped, next CplD is written
        send_cpl(8'd2, 10'd2, 12'd8, 3'b001, -1, -1);
        idle(3);
        check("ur_nwr", wq.size(), 0);
        check("ur_err", err_seen, 1);
        check("ur_ndone", cq.size(), 0);
        send_cpl(8'd2, 10'd2, 12'd8, 3'b000, -1, -1);
        idle(3);
        check("ur_next_nwr", wq.size(), 1);
        expect_wr("ur_next", 8'd2, 0, 1);
        expect_done("ur_next_done", 4'd2);
        check("ur_next_err", err_seen, 1);
        flush();

        // Poisoned payload beat: earlier writes stay, offset does not advance
        send_cpl(8'd6, 10'd4, 12'd64, 3'b000, -1, -1);
        idle(3);
        check("p_pre_nwr", wq.size(), 2);
        expect_wr("p_pre", 8'd6, 0, 2);
        send_cpl(8'd6, 10'd8, 12'd48, 3'b000, 2, -1);
        idle(3);
        check("p_err", err_seen, 2);
        check("p_nwr", wq.size(), 2);
        check("p_ndone", cq.size(), 0);
        expect_wr("p_part", 8'd6, 2, 2);
        send_cpl(8'd6, 10'd4, 12'd16, 3'b000, -1, -1);
        idle(3);
        check("p_post_nwr", wq.size(), 2);
        expect_wr("p_post", 8'd6, 2, 2);
        expect_done("p_post_done", 4'd6);
        flush();

        // Back-to-back TLPs on tags 0 and 1
        send_cpl(8'd0, 10'd4, 12'd16, 3'b000, -1, -1);
        send_cpl(8'd1, 10'd4, 12'd16, 3'b000, -1, -1);
        idle(3);
        check("b2b_nwr", wq.size(), 4);
        check("b2b_ndone", cq.size(), 2);
        expect_wr("b2b_t0", 8'd0, 0, 2);
        expect_wr("b2b_t1", 8'd1, 0, 2);
        expect_done("b2b_done0", 4'd0);
        expect_done("b2b_done1", 4'd1);
        flush();

        // Premature EOF: error, no write, offset untouched
        send_cpl(8'd7, 10'd4, 12'd16, 3'b000, -1, 0);
        idle(3);
        check("pre_err", err_seen, 3);
        check("pre_nwr", wq.size(), 0);
        check("pre_ndone", cq.size(), 0);
        send_cpl(8'd7, 10'd2, 12'd8, 3'b000, -1, -1);
        idle(3);
        check("pre_next_nwr", wq.size(), 1);
        expect_wr("pre_next", 8'd7, 0, 1);
        expect_done("pre_next_done", 4'd7);
        flush();

        // Full 64-qword slot: offset wraps back to 0
        send_cpl(8'd8, 10'd128, 12'd1024, 3'b000, -1, -1);
        idle(3);
        check("wrap_nwr", wq.size(), 64);
        check("wrap_ndone", cq.size(), 0);
        expect_wr("wrap", 8'd8, 0, 64);
        send_cpl(8'd8, 10'd2, 12'd8, 3'b000, -1, -1);
        idle(3);
        check("wrap_next_nwr", wq.size(), 1);
        expect_wr("wrap_next", 8'd8, 0, 1);
        expect_done("wrap_next_done", 4'd8);
        flush();

`ifdef RX_CPL_ERR_CNT_EN
        check("cnt_after_3", cpl_err_cnt, 16'd3);
`endif

        // Reset mid-TLP clears offsets and abandons the partial TLP
        send_cpl(8'd4, 10'd4, 12'd64, 3'b000, -1, -1);
        idle(3);
        check("mr_pre_nwr", wq.size(), 2);
        expect_wr("mr_pre", 8'd4, 0, 2);
        beat(hdr1(10'd4, 12'd16, 3'b000), 1'b1, 1'b0, 8'h00, 1'b0);
        beat({16'h0200, 8'd4, 8'h00, dw(8'd4, 0)}, 1'b0, 1'b0, 8'h00, 1'b0);
        beat({dw(8'd4, 1), dw(8'd4, 2)}, 1'b0, 1'b0, 8'h00, 1'b0);
        idle(1);
        reset_n = 1'b0;
        #2;
        check("mr_rst_dst_rdy_n", trn.trn_rdst_rdy_n, 1'b1);
        check("mr_rst_wr_en", wr_en, 1'b0);
`ifdef RX_CPL_ERR_CNT_EN
        check("cnt_after_rst", cpl_err_cnt, 16'd0);
`endif
        @(negedge trn_clk);
        reset_n = 1'b1;
        idle(2);
        flush();
        beat({dw(8'd4, 3), 32'h0}, 1'b0, 1'b1, 8'h0F, 1'b0);
        send_cpl(8'd4, 10'd2, 12'd8, 3'b000, -1, -1);
        idle(3);
        check("mr_post_nwr", wq.size(), 1);
        expect_wr("mr_post", 8'd4, 0, 1);
        check("mr_post_ndone", cq.size(), 1);
        expect_done("mr_post_done", 4'd4);
        check("mr_post_err", err_seen, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
